polirv_mem_arbiter: RTL and testbench

// - Shares one 64-bit single-port memory between the polirv fetch path (32-bit instructions) and the data path (64-bit ld/sd).
// - Sits between the core and a unified memory; the core stalls on each side until that side's ack.
// - Two-way round-robin arbiter with latched requests, variable-latency memory (m_ready) and a bus timeout with error report.

---
 rtl/polirv_mem_pkg.sv | 18 +
 rtl/arb_timeout_counter.sv | 28 ++
 rtl/polirv_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_polirv_mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/polirv_mem_pkg.sv
// Shared types and constants for the polirv memory arbiter.
package polirv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } arb_state_e;

  // Requester select: fetch side or data side.
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  localparam int ADDR_BITS_DEF   = 6;
  localparam int TIMEOUT_CYC_DEF = 15;

endpackage

// File: rtl/arb_timeout_counter.sv
// Bus timeout counter: clears while idle, counts stalled cycles, flags the last allowed one.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Count stalled cycles; hold at the terminal value so the compare never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/polirv_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory between instruction fetch and data access.
//
// state  | meaning
// IDLE   | waiting for a request; grant happens here
// ACCESS | memory strobe active, waiting for m_ready or timeout
// RESP   | ack pulse for the granted side with captured read data
// ERR    | ack pulse plus bus_err, read data forced to zero
module polirv_mem_arbiter
  import polirv_mem_pkg::*;
#(
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 i_ack,
  output logic [31:0]          i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [63:0]          d_wdata,
  output logic                 d_ack,
  output logic [63:0]          d_rdata,
  output logic                 m_en,
  output logic                 m_we,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [63:0]          m_wdata,
  input  logic [63:0]          m_rdata,
  input  logic                 m_ready,
  output logic                 bus_err,
  output logic                 busy
);

  arb_state_e           state_q, state_d;
  logic                 sel_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [63:0]          wdata_q;
  logic                 last_q;
  logic [31:0]          i_data_q;
  logic [63:0]          d_rdata_q;

  logic grant;
  logic grant_sel;
  logic tmo_tc;
  logic in_access;
  logic in_ack;

  assign in_access = (state_q == ST_ACCESS);
  assign in_ack    = (state_q == ST_RESP) || (state_q == ST_ERR);

  arb_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (!in_access),
    .en  (in_access && !m_ready),
    .tc  (tmo_tc)
  );

  // Next-state and grant decision; on a tie the side that did not win last time goes first.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_sel = SEL_I;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = ST_ACCESS;
          if (i_req && d_req) begin
            grant_sel = (last_q == SEL_I) ? SEL_D : SEL_I;
          end else begin
            grant_sel = d_req ? SEL_D : SEL_I;
          end
        end
      end
      ST_ACCESS: begin
        if (m_ready) begin
          state_d = ST_RESP;
        end else if (tmo_tc) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, request latches and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= SEL_I;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        sel_q  <= grant_sel;
        last_q <= grant_sel;
        if (grant_sel == SEL_D) begin
          we_q    <= d_we;
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= i_addr;
          wdata_q <= '0;
        end
      end
      // Stores leave the load data register untouched.
      if (in_access && m_ready) begin
        if (sel_q == SEL_I) begin
          i_data_q <= addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
        end else if (!we_q) begin
          d_rdata_q <= m_rdata;
        end
      end
    end
  end

  // Outputs decoded from state and latches; memory bus is quiet outside ACCESS.
  always_comb begin
    m_en    = in_access;
    m_we    = in_access && (sel_q == SEL_D) && we_q;
    m_addr  = in_access ? addr_q : '0;
    m_wdata = in_access ? wdata_q : '0;
    i_ack   = in_ack && (sel_q == SEL_I);
    d_ack   = in_ack && (sel_q == SEL_D);
    bus_err = (state_q == ST_ERR);
    busy    = (state_q != ST_IDLE);
    i_data  = (state_q == ST_ERR) ? 32'd0 : i_data_q;
    d_rdata = (state_q == ST_ERR) ? 64'd0 : d_rdata_q;
  end

endmodule

// File: tb/tb_polirv_mem_arbiter.sv
// Bench for polirv_mem_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_polirv_mem_arbiter;

  localparam int AW  = 6;
  localparam int TOC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [31:0]   i_data;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic          d_ack;
  logic [63:0]   d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata;
  logic          m_ready;
  logic          bus_err;
  logic          busy;

  polirv_mem_arbiter #(
    .ADDR_BITS   (AW),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_data  (i_data),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .bus_err (bus_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] mem [8];
  bit          last_d;
  logic [63:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {m_en, m_we, i_ack, d_ack, bus_err, busy}, 0);
    chk({tag, "_bus"}, {m_addr, m_wdata}, 0);
    chk({tag, "_rd"}, {i_data, d_rdata}, 0);
  endtask

  // One complete transaction starting in an idle cycle; lat = stall cycles before m_ready.
  task automatic xact(input bit ir, input bit dr, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                      input bit we, input logic [63:0] wd, input int lat);
    bit          win_d;
    bit          to;
    int          nacc;
    logic [AW-1:0] ea;
    logic [63:0] word;
    chk("idle", {busy, m_en, i_ack, d_ack, bus_err}, 0);
    win_d  = (ir && dr) ? !last_d : dr;
    last_d = win_d;
    ea     = win_d ? da : ia;
    word   = mem[ea[5:3]];
    to     = (lat >= TOC);
    nacc   = to ? TOC : lat + 1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    for (int k = 0; k < nacc; k++) begin
      step();
      chk("acc_en", {m_en, busy}, 2'b11);
      chk("acc_we", m_we, win_d && we);
      chk("acc_addr", m_addr, ea);
      if (win_d && we) chk("acc_wdata", m_wdata, wd);
      chk("acc_noack", {i_ack, d_ack, bus_err}, 0);
      m_ready = !to && (k == lat);
      m_rdata = m_ready ? word : {$urandom, $urandom};
      i_addr  = AW'($urandom);
      d_addr  = AW'($urandom);
      d_wdata = {$urandom, $urandom};
      d_we    = 1'($urandom);
      i_req   = 1'($urandom);
      d_req   = 1'($urandom);
    end
    step();
    m_ready = 1'($urandom);
    m_rdata = {$urandom, $urandom};
    i_req = 1'b0;
    d_req = 1'b0;
    chk("ack_i", i_ack, !win_d);
    chk("ack_d", d_ack, win_d);
    chk("bus_err", bus_err, to);
    chk("ack_bus", {m_en, busy}, 2'b01);
    if (!win_d) begin
      chk("i_data", i_data, to ? 64'd0 : (ea[2] ? word[63:32] : word[31:0]));
    end else if (!we) begin
      chk("d_rdata_ld", d_rdata, to ? 64'd0 : word);
      if (!to) last_rd = word;
    end else begin
      chk("d_rdata_st", d_rdata, to ? 64'd0 : last_rd);
      if (!to) mem[ea[5:3]] = wd;
    end
    step();
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_ready = 0;
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    mem[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    step();
    chk_quiet("reset");
    rst = 1'b0;
    last_d  = 1'b0;
    last_rd = '0;
    step();

    // Both requesting from reset: D, I, D, I.
    for (int n = 0; n < 4; n++) xact(1, 1, 6'h0C, 6'h08, 0, 0, 0);
    // Zero-wait fetch of the upper half.
    xact(1, 0, 6'h0C, 0, 0, 0, 0);
    // Store then read back; store ack leaves d_rdata alone.
    xact(0, 1, 0, 6'h10, 1, 64'h1234, 0);
    xact(0, 1, 0, 6'h10, 0, 0, 0);
    // m_ready arriving on the last cycle before timeout.
    xact(0, 1, 0, 6'h18, 0, 0, 3);
    // Timeouts for load, store and fetch.
    xact(0, 1, 0, 6'h20, 0, 0, 99);
    xact(0, 1, 0, 6'h28, 1, 64'hDEAD, 99);
    xact(1, 0, 6'h04, 0, 0, 0, 99);

    // Reset in the middle of an access.
    i_req = 1; d_req = 1; d_we = 1; m_ready = 0;
    step();
    chk("rst_pre_en", m_en, 1);
    rst = 1; i_req = 0; d_req = 0;
    step();
    chk_quiet("rst_mid");
    rst = 0;
    last_d  = 1'b0;
    last_rd = '0;
    step();
    xact(1, 1, 6'h00, 6'h30, 0, 0, 1);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      xact(sel[0], sel[1], AW'($urandom), AW'($urandom), 1'($urandom), {$urandom, $urandom},
           int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
